leaf_output_packetizer: RTL and testbench
=========================================

# leaf_output_packetizer

Interface-side output stage of a leaf shell. It takes up to NUM_OUT_PORTS user output streams (32-bit payload, vld/ack) already in the interface clock domain and round-robin arbitrates them onto the single 49-bit BFT output word. Each packet carries a per-port configured destination leaf/port and a 7-bit sequence address. Sending is throttled by per-port freespace credits, which are replenished by updates from the destination leaf.

## Interface
Parameters:
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user payload width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, sequence address width; initial credits = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 4, number of user output streams
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace update

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  interface clock
- reset_n  in  1  asynchronous active-low reset
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; port i at [i*32 +: 32]
- vld_user2interface  in  NUM_OUT_PORTS  payload valid per port
- ack_interface2user  out  NUM_OUT_PORTS  one-hot accept, same cycle as vld
- cfg_we  in  1  destination table write strobe
- cfg_port  in  NUM_PORT_BITS  table index; values >= NUM_OUT_PORTS are ignored
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_dest_port  in  NUM_PORT_BITS  destination port
- credit_vld  in  1  freespace update pulse
- credit_port  in  NUM_PORT_BITS  local output port being credited
- resend  in  1  stall; no new packets are issued
- dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT; bit 48 is the valid bit

## Operation
- Packet layout:
  - [48] valid
  - [47:43] dest leaf
  - [42:39] dest port
  - [38:32] sequence address
  - [31:0] payload
- Per-port state:
  - cfg_valid (reset 0)
  - dest_leaf/dest_port (reset 0)
  - credit counter, NUM_ADDR_BITS+1 bits (reset 128)
  - seq addr (reset 0)
  - rr pointer (reset 0)
- Eligibility: port i is eligible when vld[i] && cfg_valid[i] && credit[i] != 0 && !resend.
- Arbitration:
  - Grant the first eligible port scanning pointer, pointer+1, … mod NUM_OUT_PORTS.
  - At most one grant per cycle.
  - On grant g, the pointer becomes (g+1) mod NUM_OUT_PORTS; with no grant, the pointer holds.
- Handshake: ack[g]=1 in the grant cycle. The user holds vld and data stable until ack; vld may drop without ack only before a grant.
- On grant:
  - seq[g] increments, wrapping 127 -> 0.
  - credit[g] decrements.
- Credit update: credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_port].
  - The result saturates at 128.
  - credit_port >= NUM_OUT_PORTS is ignored.
- Simultaneous grant and update on the same port: net result is min(credit - 1 + 64, 128).
- Credit 0: the port is blocked, and other ports continue to be served.
- cfg write: takes effect the next cycle. A grant issued in the same cycle uses the old entry.
- resend high:
  - ack is all zero.
  - Packets already registered still appear as registered.
  - All state is preserved.

## Timing
- ack_interface2user is combinational from vld, registered state and resend. It is 0 out of reset because cfg_valid is 0.
- dout is registered. The packet for a grant in cycle N appears in cycle N+1 with bit 48 = 1.
- dout = 0 in any cycle following a cycle with no grant.
- Throughput: one packet per cycle sustained.
- Reset values: dout = 0, ack = 0, credits = 128, seq = 0, pointer = 0, cfg_valid = 0.
- Reset asserted mid-stream clears everything asynchronously. A packet that was in flight is dropped.

## Structure
- Shared package leaf_pkt_pkg holds:
  - field offsets/widths (VALID_BIT=48, LEAF_LSB=43, PORT_LSB=39, ADDR_LSB=32)
  - the packet struct typedef
  - FREESPACE_UPDATE_SIZE default
- Sub-module rr_arbiter (parameter N): request vector + pointer in, one-hot grant + grant index out, purely combinational.
- Credit counters, seq counters, destination table and output register live in the top module.

## Test plan
- Configure port 0 -> leaf 5, port 2; drive payload 0xDEADBEEF -> ack[0] same cycle; next cycle dout = {1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF}.
- All 4 ports valid and configured continuously -> grants 0,1,2,3,0,… one per cycle; seq per port increments; port 1 seq wraps 127 -> 0 on its 129th packet.
- Port 0 sends 128 packets with no updates -> credit 0, ack[0] stays low while ports 1–3 still flow; one credit_vld for port 0 -> port 0 resumes the next cycle; credit reads 64.
- credit_vld on port 2 in the same cycle as a grant at credit 100 -> credit 128 (saturated), not 163.
- resend held high for 10 cycles with all ports valid -> no ack, dout = 0 after the pipeline drains; on release the pointer resumes where it stopped.
- reset_n pulsed low during traffic -> dout = 0 and ack = 0 immediately; cfg_valid cleared, so no grants until reconfigured.

Source files
------------

// File: rtl/leaf_pkt_pkg.sv
// Shared definitions for the leaf output packetizer: BFT packet field layout and credit defaults.
// No logic; constants and the packet struct only.
// Field widths are derived from the offsets so the struct cannot drift from the layout.
package leaf_pkt_pkg;

    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;

    // Credits returned by one freespace update from the destination leaf.
    localparam int FREESPACE_UPDATE_DEFAULT = 64;

    typedef struct packed {
        logic                          vld;
        logic [VALID_BIT-LEAF_LSB-1:0] leaf;
        logic [LEAF_LSB-PORT_LSB-1:0]  port;
        logic [PORT_LSB-ADDR_LSB-1:0]  addr;
        logic [ADDR_LSB-1:0]           payload;
    } pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (mod N) wins.
// Latency: purely combinational.
// Backpressure: none; the caller masks requests that must not be granted.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        gnt,
    output logic [IDX_BITS-1:0] gnt_idx,
    output logic                gnt_vld
);

    logic [IDX_BITS:0] cand;

    // Scan ptr, ptr+1, ... wrapping at N; keep the first requester found.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IDX_BITS+1)'(k);
            if (cand >= (IDX_BITS+1)'(N)) begin
                cand = cand - (IDX_BITS+1)'(N);
            end
            if (!gnt_vld && req[cand[IDX_BITS-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_BITS-1:0];
            end
        end
        gnt[gnt_idx] = gnt_vld;
    end

endmodule

// File: rtl/leaf_output_packetizer.sv
// Arbitrates user output streams onto the BFT output word, tagging destination and sequence address.
// Latency: ack combinational in the grant cycle; packet registered, visible one cycle later.
// Backpressure: a port stalls at zero credits; resend stalls all ports; freespace updates refill credits.
module leaf_output_packetizer
    import leaf_pkt_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 4,
    parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_we,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_port,
    input  logic                                    resend,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

    localparam int IDX_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CRED_BITS = NUM_ADDR_BITS + 1;
    localparam logic [CRED_BITS:0]    CRED_MAX = (CRED_BITS+1)'(1) << NUM_ADDR_BITS;
    localparam logic [CRED_BITS:0]    CRED_INC = (CRED_BITS+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_OUT_PORTS - 1);

    logic [PAYLOAD_BITS-1:0]  payload    [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dest_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port  [NUM_OUT_PORTS];
    logic [CRED_BITS-1:0]     credit     [NUM_OUT_PORTS];
    logic [CRED_BITS-1:0]     credit_nxt [NUM_OUT_PORTS];
    logic [CRED_BITS:0]       credit_sum [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq        [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] cfg_valid;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [IDX_BITS-1:0]      grant_idx;
    logic                     grant_any;
    logic [IDX_BITS-1:0]      rr_ptr;
    pkt_t                     pkt_nxt;
    pkt_t                     dout_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
            assign payload[gi]  = din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
            assign eligible[gi] = vld_user2interface[gi] && cfg_valid[gi] &&
                                  (credit[gi] != '0) && !resend;
        end
    endgenerate

    rr_arbiter #(
        .N        (NUM_OUT_PORTS),
        .IDX_BITS (IDX_BITS)
    ) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (grant),
        .gnt_idx (grant_idx),
        .gnt_vld (grant_any)
    );

    assign ack_interface2user      = grant;
    assign dout_leaf_interface2bft = dout_q;

    // Build the packet for this cycle's grant from the current (pre-write) table entry.
    always_comb begin
        pkt_nxt = '0;
        if (grant_any) begin
            pkt_nxt.vld     = 1'b1;
            pkt_nxt.leaf    = dest_leaf[grant_idx];
            pkt_nxt.port    = dest_port[grant_idx];
            pkt_nxt.addr    = seq[grant_idx];
            pkt_nxt.payload = payload[grant_idx];
        end
    end

    // Credit next value: consume on grant, then add the update and saturate at the initial level.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit[i]};
            if (grant[i]) begin
                credit_sum[i] = credit_sum[i] - (CRED_BITS+1)'(1);
            end
            if (credit_vld && (credit_port == NUM_PORT_BITS'(i))) begin
                credit_sum[i] = credit_sum[i] + CRED_INC;
                if (credit_sum[i] > CRED_MAX) begin
                    credit_sum[i] = CRED_MAX;
                end
            end
            credit_nxt[i] = credit_sum[i][CRED_BITS-1:0];
        end
    end

    // Per-port state: destination table, credits and sequence addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_valid <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf[i] <= '0;
                dest_port[i] <= '0;
                credit[i]    <= CRED_MAX[CRED_BITS-1:0];
                seq[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (grant[i]) begin
                    seq[i] <= seq[i] + 1'b1;
                end
                if (cfg_we && (cfg_port == NUM_PORT_BITS'(i))) begin
                    cfg_valid[i] <= 1'b1;
                    dest_leaf[i] <= cfg_dest_leaf;
                    dest_port[i] <= cfg_dest_port;
                end
            end
        end
    end

    // Round-robin pointer moves just past the winner; holds when nothing is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Output register: a packet follows each grant, otherwise the word is all zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= pkt_nxt;
        end
    end

endmodule

// File: tb/tb_leaf_output_packetizer.sv
// Bench for leaf_output_packetizer: directed vector table, hand sequences and random traffic.
// Expected ack/dout come from a per-cycle reference model of the arbitration and credit rules.
// All waits are fixed cycle counts, so the run always terminates.
module tb_leaf_output_packetizer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [127:0] din = '0;
    logic [3:0]   vld = '0;
    logic [3:0]   ack;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_port = '0;
    logic [4:0]   cfg_dest_leaf = '0;
    logic [3:0]   cfg_dest_port = '0;
    logic         credit_vld = 1'b0;
    logic [3:0]   credit_port = '0;
    logic         resend = 1'b0;
    logic [48:0]  dout;

    leaf_output_packetizer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_we                  (cfg_we),
        .cfg_port                (cfg_port),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_vld              (credit_vld),
        .credit_port             (credit_port),
        .resend                  (resend),
        .dout_leaf_interface2bft (dout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state.
    int          m_cred [4];
    int          m_seq  [4];
    bit          m_cv   [4];
    logic [4:0]  m_leaf [4];
    logic [3:0]  m_port [4];
    int          m_ptr;
    logic [48:0] m_dout;

    logic [3:0]  obs_ack;
    logic [48:0] obs_dout;
    int          ack_cnt [4];

    typedef struct {
        logic [3:0]  vld;
        logic        rs;
        logic [3:0]  ack;
        logic [48:0] dout;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [48:0] pk(input logic [4:0] l, input logic [3:0] p,
                                       input logic [6:0] s, input logic [31:0] d);
        return {1'b1, l, p, s, d};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cred[i] = 128; m_seq[i] = 0; m_cv[i] = 0; m_leaf[i] = '0; m_port[i] = '0;
        end
        m_ptr = 0;
        m_dout = '0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < 4; k++) begin
            int p = (m_ptr + k) % 4;
            if (vld[p] && m_cv[p] && m_cred[p] > 0 && !resend) return p;
        end
        return -1;
    endfunction

    task automatic model_clock(input int g);
        if (g >= 0) begin
            m_dout = {1'b1, m_leaf[g], m_port[g], 7'(m_seq[g]), din[g*32 +: 32]};
            m_seq[g] = (m_seq[g] + 1) % 128;
            m_cred[g] = m_cred[g] - 1;
            m_ptr = (g + 1) % 4;
        end else begin
            m_dout = '0;
        end
        if (credit_vld && credit_port < 4) begin
            m_cred[credit_port] = m_cred[credit_port] + 64;
            if (m_cred[credit_port] > 128) m_cred[credit_port] = 128;
        end
        if (cfg_we && cfg_port < 4) begin
            m_cv[cfg_port] = 1;
            m_leaf[cfg_port] = cfg_dest_leaf;
            m_port[cfg_port] = cfg_dest_port;
        end
    endtask

    // One clock: compare ack/dout with the model at negedge, advance the model at posedge.
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant();
        obs_ack = ack;
        obs_dout = dout;
        for (int p = 0; p < 4; p++) ack_cnt[p] += int'(ack[p]);
        check("ack", {60'd0, ack}, (g >= 0) ? (64'd1 << g) : 64'd0);
        check("dout", {15'd0, dout}, {15'd0, m_dout});
        @(posedge clk);
        model_clock(g);
        #1;
    endtask

    task automatic clr_cnt();
        for (int p = 0; p < 4; p++) ack_cnt[p] = 0;
    endtask

    task automatic cfg(input logic [3:0] p, input logic [4:0] l, input logic [3:0] d);
        cfg_we = 1'b1; cfg_port = p; cfg_dest_leaf = l; cfg_dest_port = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_all();
        for (int p = 0; p < 4; p++) cfg(4'(p), 5'(p + 3), 4'(p + 8));
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear immediately.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_ack", {60'd0, ack}, 64'd0);
        check("rst_dout", {15'd0, dout}, 64'd0);
        model_reset();
        #8 reset_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 1'b0, 4'b0001, pk(5'd5,  4'd2,  7'd0, 32'hDEADBEEF)};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, pk(5'd1,  4'd3,  7'd0, 32'h11111111)};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100, pk(5'd2,  4'd4,  7'd0, 32'h22222222)};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000, pk(5'd31, 4'd15, 7'd0, 32'h33333333)};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001, pk(5'd5,  4'd2,  7'd1, 32'hDEADBEEF)};
        tbl[5]  = '{4'b0001, 1'b0, 4'b0001, pk(5'd5,  4'd2,  7'd2, 32'hDEADBEEF)};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 49'd0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 49'd0};
        tbl[8]  = '{4'b1001, 1'b0, 4'b1000, pk(5'd31, 4'd15, 7'd1, 32'h33333333)};
        tbl[9]  = '{4'b1100, 1'b0, 4'b0100, pk(5'd2,  4'd4,  7'd1, 32'h22222222)};
        tbl[10] = '{4'b0101, 1'b0, 4'b0001, pk(5'd5,  4'd2,  7'd3, 32'hDEADBEEF)};
        clr_cnt();

        // Reset state, then configure and apply the directed vector table.
        pulse_reset();
        din = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        cfg(4'd0, 5'd5, 4'd2);
        cfg(4'd1, 5'd1, 4'd3);
        cfg(4'd2, 5'd2, 4'd4);
        cfg(4'd3, 5'd31, 4'd15);
        for (int r = 0; r < 11; r++) begin
            vld = tbl[r].vld;
            resend = tbl[r].rs;
            step();
            check("tbl_ack", {60'd0, obs_ack}, {60'd0, tbl[r].ack});
            if (r > 0) check("tbl_dout", {15'd0, obs_dout}, {15'd0, tbl[r-1].dout});
        end
        vld = 4'b0000; resend = 1'b0;
        step();
        check("tbl_dout_last", {15'd0, obs_dout}, {15'd0, tbl[10].dout});

        // Table write in a grant cycle uses the old entry; out-of-range index is ignored.
        vld = 4'b0001;
        cfg_we = 1'b1; cfg_port = 4'd0; cfg_dest_leaf = 5'd7; cfg_dest_port = 4'd9;
        step();
        check("cfg_same_ack", {60'd0, obs_ack}, 64'd1);
        cfg_we = 1'b0;
        step();
        check("cfg_old_entry", {15'd0, obs_dout}, {15'd0, pk(5'd5, 4'd2, 7'd4, 32'hDEADBEEF)});
        cfg_we = 1'b1; cfg_port = 4'd4; cfg_dest_leaf = 5'd9; cfg_dest_port = 4'd1;
        step();
        check("cfg_new_entry", {15'd0, obs_dout}, {15'd0, pk(5'd7, 4'd9, 7'd5, 32'hDEADBEEF)});
        cfg_we = 1'b0;
        step();
        vld = 4'b0000;
        step();
        check("cfg_port_oob", {15'd0, obs_dout}, {15'd0, pk(5'd7, 4'd9, 7'd7, 32'hDEADBEEF)});

        // Mid-stream reset: everything clears, no grants until reconfigured.
        vld = 4'b1111;
        step();
        step();
        pulse_reset();
        step();
        check("post_rst_ack", {60'd0, obs_ack}, 64'd0);
        step();
        check("post_rst_dout", {15'd0, obs_dout}, 64'd0);

        // Credit exhaustion on port 0 while ports 1..3 keep flowing; one update restores 64.
        pulse_reset();
        cfg_all();
        vld = 4'b0001;
        repeat (128) step();
        vld = 4'b1111;
        clr_cnt();
        repeat (12) step();
        check("blocked_p0", 64'(ack_cnt[0]), 64'd0);
        check("flow_p1", 64'(ack_cnt[1]), 64'd4);
        check("flow_p3", 64'(ack_cnt[3]), 64'd4);
        credit_vld = 1'b1; credit_port = 4'd4;
        step();
        vld = 4'b0001; credit_port = 4'd0;
        step();
        check("zero_credit_ack", {60'd0, obs_ack}, 64'd0);
        credit_vld = 1'b0;
        clr_cnt();
        repeat (70) step();
        check("refill_64", 64'(ack_cnt[0]), 64'd64);

        // Update and grant together on port 2 at credit 100 saturates at 128.
        pulse_reset();
        cfg_all();
        vld = 4'b0100;
        repeat (28) step();
        credit_vld = 1'b1; credit_port = 4'd2;
        step();
        credit_vld = 1'b0;
        clr_cnt();
        repeat (140) step();
        check("saturate_128", 64'(ack_cnt[2]), 64'd128);

        // All ports streaming with periodic refills: 130 packets each, seq wraps past 127.
        pulse_reset();
        cfg_all();
        vld = 4'b1111;
        clr_cnt();
        for (int c = 0; c < 520; c++) begin
            credit_vld = (c % 16 == 15);
            credit_port = 4'((c / 16) % 4);
            step();
        end
        credit_vld = 1'b0;
        check("stream_p1", 64'(ack_cnt[1]), 64'd130);

        // Resend stall for 10 cycles, then resume from the held pointer.
        resend = 1'b1;
        clr_cnt();
        repeat (10) step();
        check("resend_acks", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]), 64'd0);
        check("resend_drain", {15'd0, obs_dout}, 64'd0);
        resend = 1'b0;
        repeat (6) step();

        // Random traffic against the model.
        pulse_reset();
        cfg_all();
        repeat (3000) begin
            vld = 4'($urandom_range(0, 15));
            resend = ($urandom_range(0, 9) == 0);
            din = {$urandom(), $urandom(), $urandom(), $urandom()};
            credit_vld = ($urandom_range(0, 63) == 0);
            credit_port = 4'($urandom_range(0, 5));
            cfg_we = ($urandom_range(0, 31) == 0);
            cfg_port = 4'($urandom_range(0, 5));
            cfg_dest_leaf = 5'($urandom());
            cfg_dest_port = 4'($urandom());
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
